// File: rtl/chacha20_poly1305_pkg.sv
// Shared constants and types for the ChaCha20-Poly1305 streaming bus front-end.
// Register word addresses, CTRL/STATUS bit positions and sequencer states.
package chacha20_poly1305_pkg;

  localparam int unsigned KEY_W   = 256;
  localparam int unsigned NONCE_W = 96;
  localparam int unsigned TAG_W   = 128;

  localparam int unsigned NUM_KEY_WORDS   = 8;
  localparam int unsigned NUM_NONCE_WORDS = 3;

  localparam int unsigned ADDR_CTRL   = 'h08;
  localparam int unsigned ADDR_STATUS = 'h09;
  localparam int unsigned ADDR_BLKCNT = 'h0A;
  localparam int unsigned ADDR_IRQ_EN = 'h0B;
  localparam int unsigned ADDR_KEY0   = 'h10;
  localparam int unsigned ADDR_NONCE0 = 'h20;
  localparam int unsigned ADDR_DATA   = 'h30;
  localparam int unsigned ADDR_TAG    = 'h40;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_LAST  = 1;
  localparam int unsigned CTRL_CLEAR = 2;

  localparam int unsigned STAT_BUSY      = 0;
  localparam int unsigned STAT_IN_FULL   = 1;
  localparam int unsigned STAT_IN_EMPTY  = 2;
  localparam int unsigned STAT_OUT_FULL  = 3;
  localparam int unsigned STAT_OUT_EMPTY = 4;
  localparam int unsigned STAT_TAG_VALID = 5;
  localparam int unsigned STAT_OVERFLOW  = 6;
  localparam int unsigned STAT_UNDERFLOW = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_WAIT_INIT,
    ST_FEED,
    ST_WAIT_BLK,
    ST_FINAL,
    ST_WAIT_TAG,
    ST_DONE
  } state_t;

endpackage

// File: rtl/chacha20_poly1305_stream_ctrl_fifo.sv
// First-word fall-through synchronous FIFO with flush; push rejected when full,
// pop ignored when empty (both judged on the pre-edge count).
module cp_sync_fifo #(
  parameter int unsigned WIDTH = 512,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/chacha20_poly1305_stream_ctrl.sv
// Register-bus front-end and autonomous sequencer for the ChaCha20-Poly1305 core:
// buffers blocks in/out through FIFOs, issues init/next/finalize and captures the tag.
module chacha20_poly1305_stream_ctrl
  import chacha20_poly1305_pkg::*;
#(
  parameter int unsigned BLOCK_W    = 512,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cs,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    address,
  input  logic [BLOCK_W-1:0]   write_data,
  output logic [BLOCK_W-1:0]   read_data,
  output logic                 irq,
  output logic                 core_init,
  output logic                 core_next,
  output logic                 core_finalize,
  output logic [KEY_W-1:0]     core_key,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic [BLOCK_W-1:0]   core_block_in,
  input  logic                 core_ready,
  input  logic                 core_out_valid,
  input  logic [BLOCK_W-1:0]   core_block_out,
  input  logic                 core_tag_valid,
  input  logic [TAG_W-1:0]     core_tag
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state, state_nxt;
  logic [31:0]        key_q   [NUM_KEY_WORDS];
  logic [31:0]        nonce_q [NUM_NONCE_WORDS];
  logic               irq_en, tag_valid, last_q, ovf, udf, pulse_d;
  logic [TAG_W-1:0]   tag_q;
  logic [CNT_W-1:0]   blkcnt;

  logic               in_full, in_empty, out_full, out_empty;
  logic [CW-1:0]      in_count, out_count;
  logic [BLOCK_W-1:0] in_dout, out_dout, rd_val;

  logic bus_wr, bus_rd, ctrl_wr, clear, start, last_set;
  logic data_push, data_pop, busy, rdy;
  logic issue_init, issue_next, issue_fin, in_pop, out_push, tag_cap;

  assign bus_wr    = cs & we;
  assign bus_rd    = cs & ~we;
  assign busy      = !(state == ST_IDLE || state == ST_DONE);
  assign ctrl_wr   = bus_wr && (address == ADDR_W'(ADDR_CTRL));
  assign clear     = ctrl_wr & write_data[CTRL_CLEAR];
  assign start     = ctrl_wr & write_data[CTRL_START] & ~clear & ~busy;
  assign last_set  = ctrl_wr & write_data[CTRL_LAST] & ~clear;
  assign data_push = bus_wr && (address == ADDR_W'(ADDR_DATA));
  assign data_pop  = bus_rd && (address == ADDR_W'(ADDR_DATA));

  // The core drops core_ready only after it has seen a command, so its ready
  // is stale during the pulse cycle and the one after it.
  assign rdy = core_ready & ~(core_init | core_next | core_finalize) & ~pulse_d;

  assign irq        = tag_valid & irq_en;
  assign core_key   = {key_q[0], key_q[1], key_q[2], key_q[3],
                       key_q[4], key_q[5], key_q[6], key_q[7]};
  assign core_nonce = {nonce_q[0], nonce_q[1], nonce_q[2]};

  cp_sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (data_push),
    .pop     (in_pop),
    .flush   (clear),
    .din     (write_data),
    .dout    (in_dout),
    .full    (in_full),
    .empty   (in_empty),
    .count   (in_count)
  );

  cp_sync_fifo #(.WIDTH(BLOCK_W), .DEPTH(FIFO_DEPTH)) u_out_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (out_push),
    .pop     (data_pop),
    .flush   (clear),
    .din     (core_block_out),
    .dout    (out_dout),
    .full    (out_full),
    .empty   (out_empty),
    .count   (out_count)
  );

  always_comb begin
    state_nxt  = state;
    issue_init = 1'b0;
    issue_next = 1'b0;
    issue_fin  = 1'b0;
    in_pop     = 1'b0;
    out_push   = 1'b0;
    tag_cap    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_INIT;
      ST_INIT: if (rdy) begin
        issue_init = 1'b1;
        state_nxt  = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: if (rdy) state_nxt = ST_FEED;
      ST_FEED: begin
        if (!in_empty && !out_full && rdy) begin
          in_pop     = 1'b1;
          issue_next = 1'b1;
          state_nxt  = ST_WAIT_BLK;
        end else if (last_q && in_empty) begin
          state_nxt = ST_FINAL;
        end
      end
      ST_WAIT_BLK: if (core_out_valid) begin
        out_push  = 1'b1;
        state_nxt = ST_FEED;
      end
      ST_FINAL: if (rdy) begin
        issue_fin = 1'b1;
        state_nxt = ST_WAIT_TAG;
      end
      ST_WAIT_TAG: if (core_tag_valid) begin
        tag_cap   = 1'b1;
        state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // CLEAR wins over everything the FSM would do this cycle.
    if (clear) begin
      state_nxt  = ST_IDLE;
      issue_init = 1'b0;
      issue_next = 1'b0;
      issue_fin  = 1'b0;
      in_pop     = 1'b0;
      out_push   = 1'b0;
      tag_cap    = 1'b0;
    end
  end

  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_W'(ADDR_STATUS): rd_val[23:0] = {8'(out_count), 8'(in_count), udf, ovf, tag_valid,
                                            out_empty, out_full, in_empty, in_full, busy};
      ADDR_W'(ADDR_BLKCNT): rd_val[CNT_W-1:0] = blkcnt;
      ADDR_W'(ADDR_IRQ_EN): rd_val[0] = irq_en;
      ADDR_W'(ADDR_DATA):   if (!out_empty) rd_val = out_dout;
      ADDR_W'(ADDR_TAG):    rd_val[TAG_W-1:0] = tag_q;
      default:              rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      core_init     <= 1'b0;
      core_next     <= 1'b0;
      core_finalize <= 1'b0;
      pulse_d       <= 1'b0;
      core_block_in <= '0;
      read_data     <= '0;
      irq_en        <= 1'b0;
      tag_valid     <= 1'b0;
      tag_q         <= '0;
      last_q        <= 1'b0;
      ovf           <= 1'b0;
      udf           <= 1'b0;
      blkcnt        <= '0;
      for (int unsigned i = 0; i < NUM_KEY_WORDS; i++)   key_q[i]   <= '0;
      for (int unsigned i = 0; i < NUM_NONCE_WORDS; i++) nonce_q[i] <= '0;
    end else begin
      state         <= state_nxt;
      core_init     <= issue_init;
      core_next     <= issue_next;
      core_finalize <= issue_fin;
      pulse_d       <= core_init | core_next | core_finalize;
      if (issue_next) core_block_in <= in_dout;
      if (bus_rd) read_data <= rd_val;

      if (clear)         last_q <= 1'b0;
      else if (last_set) last_q <= 1'b1;
      else if (start)    last_q <= 1'b0;

      if (clear | start) tag_valid <= 1'b0;
      else if (tag_cap)  tag_valid <= 1'b1;
      if (tag_cap) tag_q <= core_tag;

      if (clear) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (data_push & in_full)  ovf <= 1'b1;
        if (data_pop & out_empty) udf <= 1'b1;
      end

      if (start)         blkcnt <= '0;
      else if (out_push) blkcnt <= blkcnt + CNT_W'(1);

      if (bus_wr && address == ADDR_W'(ADDR_IRQ_EN)) irq_en <= write_data[0];
      for (int unsigned i = 0; i < NUM_KEY_WORDS; i++)
        if (bus_wr && !busy && address == ADDR_W'(ADDR_KEY0 + i)) key_q[i] <= write_data[31:0];
      for (int unsigned i = 0; i < NUM_NONCE_WORDS; i++)
        if (bus_wr && !busy && address == ADDR_W'(ADDR_NONCE0 + i)) nonce_q[i] <= write_data[31:0];
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_stream_ctrl.sv
// Directed + randomized bench for chacha20_poly1305_stream_ctrl with a behavioural
// AEAD core model (XOR mask, fixed tag, random latency) and a queue-based reference.
module tb_chacha20_poly1305_stream_ctrl;

  localparam int unsigned BW = 512;
  localparam int unsigned AW = 8;
  localparam int unsigned DEPTH = 4;

  localparam logic [AW-1:0] A_CTRL = 8'h08, A_STATUS = 8'h09, A_BLKCNT = 8'h0A, A_IRQEN = 8'h0B;
  localparam logic [AW-1:0] A_KEY = 8'h10, A_NONCE = 8'h20, A_DATA = 8'h30, A_TAG = 8'h40;

  localparam logic [BW-1:0]  MASK = {16{32'ha5a5a5a5}};
  localparam logic [127:0]   TAG  = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [31:0]    KEYW [8] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff,
                                          32'h01234567, 32'h89abcdef, 32'hfedcba98, 32'h76543210};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cs = 1'b0, we = 1'b0;
  logic [AW-1:0] address = '0;
  logic [BW-1:0] write_data = '0;
  logic [BW-1:0] read_data, core_block_in, core_block_out;
  logic          irq, core_init, core_next, core_finalize;
  logic          core_ready, core_out_valid, core_tag_valid;
  logic [255:0]  core_key;
  logic [95:0]   core_nonce;
  logic [127:0]  core_tag;

  int n_assert = 0;
  int n_fail = 0;

  int unsigned   n_init = 0, n_next = 0, n_fin = 0;
  logic          hold = 1'b0, slow = 1'b0;
  logic [BW-1:0] seen [$];

  chacha20_poly1305_stream_ctrl #(.BLOCK_W(BW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .CNT_W(32)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cs             (cs),
    .we             (we),
    .address        (address),
    .write_data     (write_data),
    .read_data      (read_data),
    .irq            (irq),
    .core_init      (core_init),
    .core_next      (core_next),
    .core_finalize  (core_finalize),
    .core_key       (core_key),
    .core_nonce     (core_nonce),
    .core_block_in  (core_block_in),
    .core_ready     (core_ready),
    .core_out_valid (core_out_valid),
    .core_block_out (core_block_out),
    .core_tag_valid (core_tag_valid),
    .core_tag       (core_tag)
  );

  always #5 clk = ~clk;

  // Core model: busy for a few cycles after any command, then strobes a result.
  logic          m_busy, m_ov, m_tv;
  int unsigned   m_cnt;
  logic [1:0]    m_kind;
  logic [BW-1:0] m_blk;

  assign core_ready     = ~m_busy & ~hold;
  assign core_out_valid = m_ov;
  assign core_block_out = m_blk;
  assign core_tag_valid = m_tv;
  assign core_tag       = TAG;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_ov <= 1'b0; m_tv <= 1'b0; m_cnt <= 0; m_kind <= 2'd0; m_blk <= '0;
    end else begin
      m_ov <= 1'b0;
      m_tv <= 1'b0;
      if (core_init | core_next | core_finalize) begin
        m_busy <= 1'b1;
        m_cnt  <= slow ? 20 : $urandom_range(1, 4);
        m_kind <= core_next ? 2'd1 : (core_finalize ? 2'd2 : 2'd0);
        if (core_init) n_init <= n_init + 1;
        if (core_next) begin
          n_next <= n_next + 1;
          seen.push_back(core_block_in);
          m_blk <= core_block_in ^ MASK;
        end
        if (core_finalize) n_fin <= n_fin + 1;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          m_busy <= 1'b0;
          m_ov   <= (m_kind == 2'd1);
          m_tv   <= (m_kind == 2'd2);
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b1; address = a; write_data = d;
    @(negedge clk);
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [BW-1:0] d);
    @(negedge clk);
    cs = 1'b1; we = 1'b0; address = a;
    @(negedge clk);
    cs = 1'b0;
    d = read_data;
  endtask

  task automatic wait_stat(input int unsigned bitn, input logic v, input string tag);
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < 200; i++) begin
      bus_read(A_STATUS, s);
      if (s[bitn] === v) break;
    end
    chk(tag, BW'(s[bitn]), BW'(v));
  endtask

  task automatic wait_next(input int unsigned target, input string tag);
    for (int i = 0; i < 300; i++) begin
      if (n_next >= target) break;
      @(negedge clk);
    end
    chk(tag, BW'(n_next), BW'(target));
  endtask

  function automatic logic [BW-1:0] rand_blk();
    logic [BW-1:0] r;
    for (int w = 0; w < 16; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [BW-1:0] bp_blk(input int unsigned b);
    logic [31:0] w;
    w = 32'hdeadbeef + b;
    return {16{w}};
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] r, blk;
    logic [BW-1:0] exp_q [$];
    logic [255:0]  kexp;
    int unsigned   b_init, b_next, b_fin, bs, nblk;

    for (int i = 0; i < 8; i++) kexp[255-32*i -: 32] = KEYW[i];

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_irq", BW'(irq), '0);
    chk("rst_pulses", BW'({core_init, core_next, core_finalize}), '0);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(A_STATUS, r); chk("rst_status", r, BW'(32'h14));
    bus_read(A_BLKCNT, r); chk("rst_blkcnt", r, '0);

    // Single block
    for (int i = 0; i < 8; i++) bus_write(A_KEY + AW'(i), BW'(KEYW[i]));
    bus_write(A_NONCE,      BW'(32'h11111111));
    bus_write(A_NONCE + 8'd1, BW'(32'h22222222));
    bus_write(A_NONCE + 8'd2, BW'(32'h33333333));
    chk("key", BW'(core_key), BW'(kexp));
    chk("nonce", BW'(core_nonce), BW'(96'h111111112222222233333333));
    bus_write(A_IRQEN, BW'(1));
    bus_read(A_IRQEN, r); chk("irq_en_rb", r, BW'(1));
    b_init = n_init; b_next = n_next; b_fin = n_fin; bs = seen.size();
    bus_write(A_DATA, {16{32'hdeadbeef}});
    bus_write(A_CTRL, BW'(3));
    wait_stat(5, 1'b1, "s1_tag_wait");
    chk("s1_irq", BW'(irq), BW'(1));
    chk("s1_ninit", BW'(n_init - b_init), BW'(1));
    chk("s1_nnext", BW'(n_next - b_next), BW'(1));
    chk("s1_nfin", BW'(n_fin - b_fin), BW'(1));
    chk("s1_blkin", (seen.size() > bs) ? seen[bs] : '0, {16{32'hdeadbeef}});
    bus_read(A_DATA, r);   chk("s1_out", r, {16{32'h7b081b4a}});
    bus_read(A_TAG, r);    chk("s1_tag", r, BW'(TAG));
    bus_read(A_BLKCNT, r); chk("s1_blkcnt", r, BW'(1));
    bus_read(A_STATUS, r); chk("s1_status", r, BW'(32'h34));

    // Overflow with core stalled
    bus_write(A_CTRL, BW'(4));
    chk("clr_irq", BW'(irq), '0);
    hold = 1'b1;
    b_next = n_next; bs = seen.size();
    bus_write(A_CTRL, BW'(1));
    exp_q = {};
    for (int i = 0; i < 5; i++) begin
      blk = rand_blk();
      bus_write(A_DATA, blk);
      if (exp_q.size() < DEPTH) exp_q.push_back(blk);
    end
    bus_read(A_STATUS, r); chk("ovf_status", r, BW'(32'h453));
    hold = 1'b0;
    bus_write(A_CTRL, BW'(2));
    wait_stat(5, 1'b1, "ovf_tag_wait");
    chk("ovf_nnext", BW'(n_next - b_next), BW'(DEPTH));
    for (int i = 0; i < 4; i++)
      chk("ovf_blkin", (seen.size() > bs + i) ? seen[bs+i] : '0, exp_q[i]);
    bus_read(A_STATUS, r); chk("ovf_status_done", r, BW'(32'h4006C));
    for (int i = 0; i < 4; i++) begin
      bus_read(A_DATA, r); chk("ovf_out", r, exp_q[i] ^ MASK);
    end
    bus_read(A_STATUS, r); chk("ovf_status_drained", r, BW'(32'h74));
    bus_read(A_DATA, r);   chk("udf_data", r, '0);
    bus_read(A_STATUS, r); chk("udf_status", r, BW'(32'hF4));
    bus_read(A_BLKCNT, r); chk("ovf_blkcnt", r, BW'(4));

    // Back-pressure: output FIFO fills and stalls the feed
    bus_write(A_CTRL, BW'(4));
    b_init = n_init; b_next = n_next; b_fin = n_fin;
    exp_q = {};
    for (int b = 0; b < 4; b++) begin
      bus_write(A_DATA, bp_blk(b)); exp_q.push_back(bp_blk(b));
    end
    bus_write(A_CTRL, BW'(1));
    for (int b = 4; b < 8; b++) begin
      wait_stat(1, 1'b0, "bp_in_space");
      bus_write(A_DATA, bp_blk(b)); exp_q.push_back(bp_blk(b));
    end
    wait_stat(3, 1'b1, "bp_out_full");
    repeat (20) @(negedge clk);
    chk("bp_stall_nnext", BW'(n_next - b_next), BW'(4));
    bus_read(A_STATUS, r); chk("bp_in_count", BW'(r[15:8]), BW'(4));
    for (int i = 0; i < 2; i++) begin
      bus_read(A_DATA, r); chk("bp_out", r, exp_q[i] ^ MASK);
    end
    for (int b = 8; b < 10; b++) begin
      wait_stat(1, 1'b0, "bp_in_space");
      bus_write(A_DATA, bp_blk(b)); exp_q.push_back(bp_blk(b));
    end
    bus_write(A_CTRL, BW'(2));
    for (int i = 2; i < 10; i++) begin
      wait_stat(4, 1'b0, "bp_out_avail");
      bus_read(A_DATA, r); chk("bp_out", r, exp_q[i] ^ MASK);
    end
    wait_stat(5, 1'b1, "bp_tag_wait");
    bus_read(A_BLKCNT, r); chk("bp_blkcnt", r, BW'(10));
    chk("bp_nnext", BW'(n_next - b_next), BW'(10));
    chk("bp_nfin", BW'(n_fin - b_fin), BW'(1));
    chk("bp_ninit", BW'(n_init - b_init), BW'(1));

    // Random streams
    for (int round = 0; round < 3; round++) begin
      nblk = $urandom_range(1, DEPTH);
      exp_q = {};
      for (int i = 0; i < int'(nblk); i++) begin
        blk = rand_blk(); bus_write(A_DATA, blk); exp_q.push_back(blk);
      end
      bus_write(A_CTRL, BW'(3));
      wait_stat(5, 1'b1, "rnd_tag_wait");
      for (int i = 0; i < int'(nblk); i++) begin
        bus_read(A_DATA, r); chk("rnd_out", r, exp_q[i] ^ MASK);
      end
      bus_read(A_BLKCNT, r); chk("rnd_blkcnt", r, BW'(nblk));
    end

    // CLEAR while waiting for a block, followed by a late strobe
    bus_write(A_CTRL, BW'(4));
    slow = 1'b1;
    b_next = n_next; b_fin = n_fin;
    bus_write(A_DATA, rand_blk());
    bus_write(A_CTRL, BW'(3));
    wait_next(b_next + 1, "clr_next_wait");
    repeat (2) @(negedge clk);
    bus_write(A_CTRL, BW'(4));
    repeat (40) @(negedge clk);
    slow = 1'b0;
    bus_read(A_STATUS, r); chk("clr_status", r, BW'(32'h14));
    bus_read(A_BLKCNT, r); chk("clr_blkcnt", r, '0);
    chk("clr_nfin", BW'(n_fin - b_fin), '0);

    // Busy lock in FEED
    b_init = n_init;
    bus_write(A_CTRL, BW'(1));
    repeat (20) @(negedge clk);
    bus_read(A_STATUS, r); chk("lock_status", r, BW'(32'h15));
    bus_write(A_KEY, BW'(32'hffffffff));
    bus_write(A_CTRL, BW'(1));
    repeat (10) @(negedge clk);
    chk("lock_key", BW'(core_key), BW'(kexp));
    chk("lock_ninit", BW'(n_init - b_init), BW'(1));

    // Asynchronous reset mid-FEED
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_key", BW'(core_key), '0);
    chk("arst_nonce", BW'(core_nonce), '0);
    chk("arst_blkin", core_block_in, '0);
    chk("arst_rdata", read_data, '0);
    chk("arst_misc", BW'({irq, core_init, core_next, core_finalize}), '0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(A_STATUS, r); chk("arst_status", r, BW'(32'h14));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/chacha20_poly1305_stream_ctrl.md
Name: chacha20_poly1305_stream_ctrl

Overview:
- Parametrised bus front-end and sequencer for the ChaCha20-Poly1305 AEAD core, succeeding the single-block register bus.
- Buffers plaintext blocks in an input FIFO and issues init/next/finalize to the core autonomously.
- Collects core outputs in an output FIFO, counts blocks, captures the tag and raises an interrupt.
- Sits between the system register bus and the AEAD core.

Parameters:
- BLOCK_W, 512: data block and bus data width.
- ADDR_W, 8: bus address width.
- FIFO_DEPTH, 4: entries per FIFO. Must be a power of 2, from 2 to 128.
- CNT_W, 32: width of the block counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- cs  in  1  bus select
- we  in  1  bus write enable
- address  in  ADDR_W  register word address
- write_data  in  BLOCK_W  bus write data
- read_data  out  BLOCK_W  registered read data
- irq  out  1  level interrupt: tag_valid & irq_en
- core_init, core_next, core_finalize  out  1 each  one-cycle command pulses
- core_key  out  256  key registers {k0..k7}
- core_nonce  out  96  nonce registers {n0..n2}
- core_block_in  out  BLOCK_W  block presented with core_next
- core_ready  in  1  core idle and able to accept a command
- core_out_valid  in  1  one-cycle strobe; core_block_out valid
- core_block_out  in  BLOCK_W  processed block
- core_tag_valid  in  1  one-cycle strobe; core_tag valid
- core_tag  in  128  Poly1305 tag

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous and active-low. Reset clears every register and output to 0, both FIFOs to empty, and the FSM to IDLE.
- Bus write: action on the posedge where cs&we.
- Bus read: on the posedge where cs&~we, read_data is loaded. The value is visible from the next cycle. Unmapped addresses read 0.
- Register map, 0x08 CTRL (write-only):
  - bit0 START: honoured in IDLE/DONE only. Clears BLKCNT, tag_valid and the LAST latch, then goes to INIT.
  - bit1 LAST: sets the LAST latch in any state. START with LAST in one write does both.
  - bit2 CLEAR: overrides START and LAST. Forces IDLE, flushes both FIFOs, clears tag_valid, sticky flags and LAST. No command pulse is issued.
- Register map, 0x09 STATUS (read-only):
  - bit0 busy (state not IDLE/DONE)
  - bit1 in_full, bit2 in_empty
  - bit3 out_full, bit4 out_empty
  - bit5 tag_valid
  - bit6 overflow (sticky), bit7 underflow (sticky)
  - [15:8] in_count, [23:16] out_count; remaining bits 0.
- Register map, other addresses:
  - 0x0A BLKCNT: read-only, CNT_W bits, wraps to 0 at 2^CNT_W.
  - 0x0B IRQ_EN: bit0, read/write.
  - 0x10-0x17 key words, 0x20-0x22 nonce words: use write_data[31:0]. Writes are dropped while busy.
  - 0x30 write: push to input FIFO. If in_full, the data is dropped and overflow is set. Fullness uses the pre-edge count, so a push and FSM pop on the same edge while full is still rejected.
  - 0x30 read: pop from output FIFO. If empty, returns 0 and sets underflow. A core push and bus pop on the same edge are both honoured.
  - 0x40 TAG: read-only, zero-extended.
- FSM states: IDLE, INIT, WAIT_INIT, FEED, WAIT_BLK, FINAL, WAIT_TAG, DONE.
- Ready sampling: core_ready is ignored in the cycle immediately after any command pulse; it is sampled from the second cycle on.
- Transitions:
  - INIT: when core_ready, pulse core_init and go to WAIT_INIT.
  - WAIT_INIT: when core_ready, go to FEED.
  - FEED, issue: if in FIFO non-empty, out FIFO not full and core_ready, then pop, register core_block_in, pulse core_next in the same cycle the block is presented, and go to WAIT_BLK.
  - FEED, finish: else if LAST and in FIFO empty, go to FINAL.
  - FEED, otherwise: wait.
  - WAIT_BLK: on core_out_valid, push core_block_out to the out FIFO, increment BLKCNT, and go to FEED.
  - FINAL: when core_ready, pulse core_finalize and go to WAIT_TAG.
  - WAIT_TAG: on core_tag_valid, capture core_tag, set tag_valid, and go to DONE.
- Flow limits: at most one block in flight. The out-not-full check guarantees the output FIFO never overflows.
- Stray strobes: core_out_valid and core_tag_valid are ignored outside WAIT_BLK and WAIT_TAG. This includes a late strobe after CLEAR.
- Pulse timing: core pulses are exactly one cycle wide, driven from flops.

Decomposition:
- Package chacha20_poly1305_pkg holds:
  - register address constants;
  - CTRL/STATUS bit indices;
  - the FSM state enum;
  - KEY_W=256, NONCE_W=96, TAG_W=128.
- One sub-module, cp_sync_fifo (parameters WIDTH and DEPTH), instantiated twice:
  - ports push, pop, din, dout, full, empty, count, flush;
  - first-word fall-through.

Test Plan:
- Reset: read 0x09 gives 0x14. Read 0x0A gives 0. irq=0 and all core pulses 0.
- Single block:
  - Stimulus: key 00112233..76543210, nonce 11111111/22222222/33333333, push {16{deadbeef}}, CTRL=0x3. Core model returns block^{16{a5a5a5a5}} and tag 0x0123..cdef.
  - Response: exactly one each of core_init, core_next and core_finalize. core_block_in={16{deadbeef}}. 0x30 reads {16{7b081b4a}}. 0x40 reads the tag. BLKCNT=1. STATUS=0x34.
- Overflow: DEPTH=4, core_ready held 0, push 5 blocks. STATUS shows in_count=4, in_full=1, overflow=1. The 5th block never appears on core_block_in.
- Back-pressure:
  - Stimulus: push deadbeef+blk for blk=0..9 interleaved with CTRL=0x3; no reads until out_full.
  - Response: core_next count stalls at 4. Reads then return blocks in order. Final BLKCNT=10, 10 core_next, 1 core_finalize.
- CLEAR mid-operation: CLEAR in WAIT_BLK, then a late core_out_valid. Result: IDLE, STATUS=0x14, no push and no core_finalize. Asserting reset_n=0 mid-FEED zeroes all outputs asynchronously.
- Busy lock: during FEED, write key 0x10=ffffffff and CTRL=0x1. core_key is unchanged and only one core_init has been issued.
